// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg
//   Shared definitions for the UART-to-register bridge:
//   - state_t   : bridge FSM state encoding
//   - CMD_WR    : command byte that opens a write frame ('W')
//   - CMD_RD    : command byte that opens a read frame ('R')
//   - ACK_BYTE  : byte returned once a write has been issued ('K')
package uart_reg_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        ADDR_HI = 4'd1,
        ADDR_LO = 4'd2,
        BE      = 4'd3,
        DATA    = 4'd4,
        WR_STB  = 4'd5,
        WR_ACK  = 4'd6,
        RD_STB  = 4'd7,
        RD_WAIT = 4'd8,
        RD_SEND = 4'd9
    } state_t;

    localparam logic [7:0] CMD_WR   = 8'h57;
    localparam logic [7:0] CMD_RD   = 8'h52;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

endpackage

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
//   Turns a byte stream from a UART receiver into register-bus accesses
//   and returns responses through a UART transmitter.
//     write frame: 57 addr_hi addr_lo be d3 d2 d1 d0  -> wr_en pulse, reply 4B
//     read frame : 52 addr_hi addr_lo                 -> rd_en pulse, reply 4 bytes MSB first
//
// Ports
//   clk       in   system clock, rising edge
//   rstb      in   asynchronous active-low reset
//   rx_data   in   [7:0] received byte, qualified by rx_valid
//   rx_valid  in   one-cycle strobe per received byte (no backpressure)
//   tx_data   out  [7:0] response byte
//   tx_valid  out  response byte valid
//   tx_ready  in   transmitter accepts tx_data
//   wr_en     out  register write strobe
//   rd_en     out  register read strobe
//   addr      out  [15:0] register address
//   be        out  [3:0] byte enables
//   wr_data   out  [31:0] write data
//   rd_rdy    in   qualifies rd_data
//   rd_data   in   [31:0] register read data
//   busy      out  FSM is not IDLE
//   frame_err out  one-cycle pulse on a dropped byte or a frame timeout
module uart_reg_bridge
    import uart_reg_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rstb,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        wr_en,
    output logic        rd_en,
    output logic [15:0] addr,
    output logic [3:0]  be,
    output logic [31:0] wr_data,
    input  logic        rd_rdy,
    input  logic [31:0] rd_data,
    output logic        busy,
    output logic        frame_err
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t        r_state;
    logic          r_mode_wr;
    logic [15:0]   r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wr_data;
    logic [31:0]   r_shift;
    logic [1:0]    r_cnt;
    logic [TW-1:0] r_timer;
    logic          r_frame_err;

    state_t        w_next;
    logic          w_err;
    logic          w_timed;
    logic          w_timeout;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_tx_valid;
    logic [7:0]    w_tx_data;

    // States in which the bridge is waiting on an outside party and the
    // inter-byte / read-response timer is allowed to run.
    assign w_timed = (r_state == ADDR_HI) || (r_state == ADDR_LO) ||
                     (r_state == BE)      || (r_state == DATA)    ||
                     (r_state == RD_WAIT);

    // An arriving byte always beats an expiring timer.
    assign w_timeout = w_timed && !rx_valid && (r_timer == TO_LAST);

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_err      = 1'b0;
        w_wr_en    = 1'b0;
        w_rd_en    = 1'b0;
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
        case (r_state)
            IDLE: begin
                if (rx_valid) begin
                    if ((rx_data == CMD_WR) || (rx_data == CMD_RD)) begin
                        w_next = ADDR_HI;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            ADDR_HI: begin
                if (rx_valid) begin
                    w_next = ADDR_LO;
                end else if (w_timeout) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            ADDR_LO: begin
                if (rx_valid) begin
                    w_next = r_mode_wr ? BE : RD_STB;
                end else if (w_timeout) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            BE: begin
                if (rx_valid) begin
                    w_next = DATA;
                end else if (w_timeout) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            DATA: begin
                if (rx_valid) begin
                    if (r_cnt == 2'd3) begin
                        w_next = WR_STB;
                    end
                end else if (w_timeout) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            WR_STB: begin
                w_wr_en = 1'b1;
                w_err   = rx_valid;
                w_next  = WR_ACK;
            end
            WR_ACK: begin
                w_tx_valid = 1'b1;
                w_tx_data  = ACK_BYTE;
                w_err      = rx_valid;
                if (tx_ready) begin
                    w_next = IDLE;
                end
            end
            RD_STB: begin
                w_rd_en = 1'b1;
                w_err   = rx_valid;
                w_next  = RD_WAIT;
            end
            RD_WAIT: begin
                w_err = rx_valid;
                if (rd_rdy) begin
                    w_next = RD_SEND;
                end else if (w_timeout) begin
                    w_next = IDLE;
                    w_err  = 1'b1;
                end
            end
            RD_SEND: begin
                w_tx_valid = 1'b1;
                w_tx_data  = r_shift[31:24];
                w_err      = rx_valid;
                if (tx_ready && (r_cnt == 2'd3)) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_mode_wr   <= 1'b0;
            r_addr      <= 16'h0000;
            r_be        <= 4'h0;
            r_wr_data   <= 32'h0000_0000;
            r_shift     <= 32'h0000_0000;
            r_cnt       <= 2'd0;
            r_timer     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;

            // Timer restarts on every byte and every state change; it only
            // counts while a frame or read response is outstanding.
            if (rx_valid || (w_next != r_state) || !w_timed) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TW'(1);
            end

            case (r_state)
                IDLE: begin
                    if (rx_valid && ((rx_data == CMD_WR) || (rx_data == CMD_RD))) begin
                        r_mode_wr <= (rx_data == CMD_WR);
                    end
                end
                ADDR_HI: begin
                    if (rx_valid) begin
                        r_addr[15:8] <= rx_data;
                    end
                end
                ADDR_LO: begin
                    if (rx_valid) begin
                        r_addr[7:0] <= rx_data;
                    end
                end
                BE: begin
                    if (rx_valid) begin
                        r_be  <= rx_data[3:0];
                        r_cnt <= 2'd0;
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        r_wr_data <= {r_wr_data[23:0], rx_data};
                        r_cnt     <= r_cnt + 2'd1;
                    end
                end
                RD_WAIT: begin
                    if (rd_rdy) begin
                        r_shift <= rd_data;
                        r_cnt   <= 2'd0;
                    end
                end
                RD_SEND: begin
                    // Shift only on a handshake so tx_data holds during stalls.
                    if (tx_ready) begin
                        r_shift <= {r_shift[23:0], 8'h00};
                        r_cnt   <= r_cnt + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wr_en     = w_wr_en;
    assign rd_en     = w_rd_en;
    assign tx_valid  = w_tx_valid;
    assign tx_data   = w_tx_data;
    assign addr      = r_addr;
    assign be        = r_be;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state != IDLE);
    assign frame_err = r_frame_err;

endmodule

// File: doc/uart_reg_bridge.md
UART_REG_BRIDGE -- requirements
Module: uart_reg_bridge

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 100000, giving the maximum idle clocks between bytes of one frame and the maximum wait for rd_rdy.
REQ-002 The block SHALL have port clk, input, 1 bit, the system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rstb, input, 1 bit, the reset: asynchronous, active-low.
REQ-004 The block SHALL have port rx_data, input, 8 bits, a received UART byte, qualified by rx_valid.
REQ-005 The block SHALL have port rx_valid, input, 1 bit, a single-cycle strobe per received byte; there is no backpressure.
REQ-006 The block SHALL have port tx_data, output, 8 bits, the response byte to the UART transmitter.
REQ-007 The block SHALL have port tx_valid, output, 1 bit; a byte transfers on any cycle where tx_valid and tx_ready are both 1.
REQ-008 The block SHALL have port tx_ready, input, 1 bit, the transmitter accept signal.
REQ-009 The block SHALL have port wr_en, output, 1 bit, the register write strobe.
REQ-010 The block SHALL have port rd_en, output, 1 bit, the register read strobe.
REQ-011 The block SHALL have port addr, output, 16 bits, the register address.
REQ-012 The block SHALL have port be, output, 4 bits, the byte enables.
REQ-013 The block SHALL have port wr_data, output, 32 bits, the write data.
REQ-014 The block SHALL have port rd_rdy, input, 1 bit; it qualifies rd_data.
REQ-015 The block SHALL have port rd_data, input, 32 bits, the register read data.
REQ-016 The block SHALL have port busy, output, 1 bit, set to 1 whenever the state is not IDLE.
REQ-017 The block SHALL have port frame_err, output, 1 bit, a one-cycle error pulse.

Function
REQ-018 The frame formats SHALL be: write = 0x57, addr[15:8], addr[7:0], be, d[31:24], d[23:16], d[15:8], d[7:0]; read = 0x52, addr[15:8], addr[7:0].
REQ-019 The state machine SHALL have states IDLE, ADDR_HI, ADDR_LO, BE, DATA, WR_STB, WR_ACK, RD_STB, RD_WAIT, RD_SEND.
REQ-020 In IDLE, a byte 0x57 SHALL move the FSM to ADDR_HI with mode write, 0x52 SHALL move it to ADDR_HI with mode read, and any other byte SHALL be dropped with a frame_err pulse on the next cycle.
REQ-021 The FSM SHALL step ADDR_HI -> ADDR_LO on the next byte; from ADDR_LO the next byte SHALL go to BE if mode is write or to RD_STB if mode is read; BE -> DATA on the next byte.
REQ-022 DATA SHALL use a 2-bit byte counter, assemble the data MSB first, and go to WR_STB after the 4th byte.
REQ-023 WR_STB SHALL assert wr_en for exactly 1 cycle, one clock after the last data byte is accepted, then go to WR_ACK.
REQ-024 WR_ACK SHALL present tx_data = 0x4B with tx_valid = 1 until the handshake completes, then go to IDLE.
REQ-025 RD_STB SHALL assert rd_en for exactly 1 cycle, one clock after the addr_lo byte, then go to RD_WAIT.
REQ-026 RD_WAIT SHALL capture rd_data into a 32-bit shift register on rd_rdy = 1, reset the byte counter, and go to RD_SEND.
REQ-027 RD_SEND SHALL send 4 bytes MSB first; it shall advance one byte per tx handshake and go to IDLE after the 4th byte.
REQ-028 While tx_valid = 1 and tx_ready = 0, tx_data SHALL be held stable.
REQ-029 addr, be and wr_data SHALL be updated only by bytes of the frame being received and SHALL hold their value between frames.
REQ-030 An inter-byte timer SHALL clear on each accepted byte and on each state change.
REQ-031 In ADDR_HI, ADDR_LO, BE, DATA or RD_WAIT, reaching TIMEOUT_CYC idle clocks SHALL return the FSM to IDLE with one frame_err pulse; no strobe shall be issued.
REQ-032 If rx_valid = 1 in WR_STB, WR_ACK, RD_STB, RD_WAIT or RD_SEND, the byte SHALL be dropped with a frame_err pulse, and the FSM SHALL continue unaffected.
REQ-033 If rx_valid = 1 and a timeout occur in the same cycle, the byte SHALL win and the timer SHALL clear.
REQ-034 wr_en and rd_en SHALL never be high in the same cycle.

Reset
REQ-035 On rstb low, asynchronously: state SHALL = IDLE; wr_en, rd_en, tx_valid, busy and frame_err SHALL = 0; tx_data, addr, be and wr_data SHALL = 0; the timer, byte counter and shift register SHALL = 0.
REQ-036 A reset in mid-frame or mid-response SHALL abandon the frame with no strobe and no further tx bytes.

Structure
REQ-037 Package uart_reg_pkg SHALL hold the state enum and the constants CMD_WR = 8'h57, CMD_RD = 8'h52 and ACK_BYTE = 8'h4B.
REQ-038 The block SHALL be a single module with no sub-module; the timer and shifter are inline.

Verification
REQ-039 Write: bytes 57 00 00 0F 12 34 56 78 -> one wr_en pulse with addr = 0x0000, be = 0xF, wr_data = 0x12345678, then tx byte 0x4B.
REQ-040 Read: bytes 52 00 00, rd_rdy one cycle after rd_en with rd_data = 0xAB000102 -> tx bytes AB 00 01 02 in order, busy low afterwards.
REQ-041 Backpressure: tx_ready low for 5 cycles per byte during a read -> tx_data stable each stall, all 4 bytes correct.
REQ-042 Timeout with TIMEOUT_CYC = 16: bytes 57 00 then silence -> frame_err pulse at 16 idle clocks, no wr_en, next frame OK.
REQ-043 Bad command byte 0x41 -> frame_err pulse, state stays IDLE; also an rx byte during RD_SEND -> frame_err pulse with the response intact.
REQ-044 Reset asserted during DATA -> outputs return to their reset values, no wr_en, and a clean frame after reset succeeds.
